// File: rtl/collide_sweeper.sv
// collide_sweeper
// Sweeps grid cells 0..NUM_CELLS-1 through an external collision stage.
// Each cell is read from BRAM, handed to the collision stage, and the
// collided result is written back to the same address. The collision stage
// returns results in order, so a FIFO of issued addresses tells each result
// where it goes. The number of cells in flight is capped at FIFO_DEPTH.
//
// Ports
//   clk_in, rst_in     : clock, asynchronous active-high reset
//   start_in           : sweep start pulse, honoured only while idle
//   bram_raddr_out     : BRAM read address (the read counter)
//   bram_rdata_in      : nine densities of the addressed cell, BRAM_LAT later
//   coll_data_out      : densities passed to the collision stage
//   coll_valid_out     : coll_data_out valid
//   coll_result_in     : collided densities
//   coll_done_in       : coll_result_in valid
//   bram_waddr_out / bram_wdata_out / bram_we_out : write-back port
//   busy_out           : sweep in progress (ISSUE or DRAIN)
//   sweep_done_out     : one-cycle end-of-sweep pulse
//   error_out          : sticky protocol error
module collide_sweeper #(
  parameter int NUM_CELLS  = 3072,
  parameter int ADDR_W     = 12,
  parameter int BRAM_LAT   = 2,
  parameter int FIFO_DEPTH = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  output logic [ADDR_W-1:0] bram_raddr_out,
  input  logic [8:0][7:0]   bram_rdata_in,
  output logic [8:0][7:0]   coll_data_out,
  output logic              coll_valid_out,
  input  logic [8:0][7:0]   coll_result_in,
  input  logic              coll_done_in,
  output logic [ADDR_W-1:0] bram_waddr_out,
  output logic [8:0][7:0]   bram_wdata_out,
  output logic              bram_we_out,
  output logic              busy_out,
  output logic              sweep_done_out,
  output logic              error_out
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CELLS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FINISH} state_t;

  state_t                           state_q, state_d;
  logic [ADDR_W-1:0]                rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]                 outst_q, outst_d;
  logic [CNT_W-1:0]                 fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]                 wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]                 rd_ptr_q, rd_ptr_d;
  logic                             error_q, error_d;
  logic [BRAM_LAT-1:0]              sr_vld_q, sr_vld_d;
  logic [BRAM_LAT-1:0][ADDR_W-1:0]  sr_addr_q, sr_addr_d;
  logic [ADDR_W-1:0]                fifo_mem [FIFO_DEPTH];

  logic              issue;
  logic              push;
  logic              push_ok;
  logic              pop;
  logic [ADDR_W-1:0] push_addr;

  // A read is issued only while the in-flight count leaves room in the FIFO,
  // which keeps pushes from ever meeting a full FIFO in legal operation.
  assign issue     = (state_q == S_ISSUE) && (outst_q < DEPTH_C);
  assign push      = sr_vld_q[BRAM_LAT-1];
  assign push_addr = sr_addr_q[BRAM_LAT-1];
  assign pop       = coll_done_in && (fifo_cnt_q != '0);
  // Pop is applied first, so a full FIFO still accepts a push alongside a pop.
  assign push_ok   = push && ((fifo_cnt_q != DEPTH_C) || pop);

  // Address/valid delay line matching the BRAM read latency.
  genvar gi;
  generate
    for (gi = 0; gi < BRAM_LAT; gi++) begin : g_sr
      if (gi == 0) begin : g_head
        assign sr_vld_d[gi]  = issue;
        assign sr_addr_d[gi] = rd_cnt_q;
      end else begin : g_tail
        assign sr_vld_d[gi]  = sr_vld_q[gi-1];
        assign sr_addr_d[gi] = sr_addr_q[gi-1];
      end
    end
  endgenerate

  // State register and datapath flops.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      rd_cnt_q   <= '0;
      outst_q    <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      error_q    <= 1'b0;
      sr_vld_q   <= '0;
      sr_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      outst_q    <= outst_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      error_q    <= error_d;
      sr_vld_q   <= sr_vld_d;
      sr_addr_q  <= sr_addr_d;
    end
  end

  // FIFO storage; contents are only observed through a pop, so no reset.
  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_q] <= push_addr;
    end
  end

  // Next-state and read counter.
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          state_d  = S_ISSUE;
          rd_cnt_d = '0;
        end
      end
      S_ISSUE: begin
        if (issue) begin
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (rd_cnt_q == LAST_ADDR) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (outst_q == '0) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Occupancy, pointers and sticky error.
  always_comb begin
    outst_d    = outst_q + {{PTR_W{1'b0}}, issue} - {{PTR_W{1'b0}}, pop};
    fifo_cnt_d = fifo_cnt_q + {{PTR_W{1'b0}}, push_ok} - {{PTR_W{1'b0}}, pop};
    wr_ptr_d   = wr_ptr_q + {{(PTR_W-1){1'b0}}, push_ok};
    rd_ptr_d   = rd_ptr_q + {{(PTR_W-1){1'b0}}, pop};
    // A result with no address to return to, or an address with no room.
    error_d    = error_q | (coll_done_in && (fifo_cnt_q == '0)) | (push && !push_ok);
  end

  // Outputs.
  always_comb begin
    busy_out       = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    sweep_done_out = (state_q == S_FINISH);
    error_out      = error_q;
    bram_raddr_out = rd_cnt_q;
    coll_valid_out = push;
    // Densities pass straight through untouched; zero when not valid.
    coll_data_out  = push ? bram_rdata_in : '0;
    bram_we_out    = pop;
    bram_waddr_out = pop ? fifo_mem[rd_ptr_q] : '0;
    bram_wdata_out = pop ? coll_result_in : '0;
  end

endmodule

// File: tb/tb_collide_sweeper.sv
// Bench for collide_sweeper. Two instances share clock and reset:
//   dut0: NUM_CELLS=4,  FIFO_DEPTH=32
//   dut1: NUM_CELLS=16, FIFO_DEPTH=4 (forces issue stalls)
// Each has a 2-cycle BRAM model (cell k holds bytes k) and a 20-cycle
// collision model (bytes + 1). Expected write-back: address k, bytes k+1.
module tb_collide_sweeper;
  localparam int AW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst = 1'b1;
  logic [1:0]               start = '0;
  logic [1:0]               inj = '0;
  logic [1:0][AW-1:0]       raddr, waddr;
  logic [1:0][8:0][7:0]     rdata, cdata, cres, wdata;
  logic [1:0]               cvalid, cdone, we, busy, sdone, err;

  collide_sweeper #(.NUM_CELLS(4), .ADDR_W(AW), .BRAM_LAT(2), .FIFO_DEPTH(32)) dut0 (
    .clk_in(clk), .rst_in(rst), .start_in(start[0]),
    .bram_raddr_out(raddr[0]), .bram_rdata_in(rdata[0]),
    .coll_data_out(cdata[0]), .coll_valid_out(cvalid[0]),
    .coll_result_in(cres[0]), .coll_done_in(cdone[0]),
    .bram_waddr_out(waddr[0]), .bram_wdata_out(wdata[0]), .bram_we_out(we[0]),
    .busy_out(busy[0]), .sweep_done_out(sdone[0]), .error_out(err[0]));

  collide_sweeper #(.NUM_CELLS(16), .ADDR_W(AW), .BRAM_LAT(2), .FIFO_DEPTH(4)) dut1 (
    .clk_in(clk), .rst_in(rst), .start_in(start[1]),
    .bram_raddr_out(raddr[1]), .bram_rdata_in(rdata[1]),
    .coll_data_out(cdata[1]), .coll_valid_out(cvalid[1]),
    .coll_result_in(cres[1]), .coll_done_in(cdone[1]),
    .bram_waddr_out(waddr[1]), .bram_wdata_out(wdata[1]), .bram_we_out(we[1]),
    .busy_out(busy[1]), .sweep_done_out(sdone[1]), .error_out(err[1]));

  // ---------------- BRAM and collision-stage models ----------------
  logic [1:0][AW-1:0] a1_q, a2_q;
  logic [1:0][19:0]   cv_q;
  logic [8:0][7:0]    cd_q [2][20];

  function automatic logic [8:0][7:0] plus_one(input logic [8:0][7:0] d);
    logic [8:0][7:0] r;
    for (int b = 0; b < 9; b++) r[b] = d[b] + 8'd1;
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a1_q <= '0;
      a2_q <= '0;
      cv_q <= '0;
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 20; j++) cd_q[i][j] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        a1_q[i] <= raddr[i];
        a2_q[i] <= a1_q[i];
        cv_q[i] <= {cv_q[i][18:0], cvalid[i]};
        cd_q[i][0] <= plus_one(cdata[i]);
        for (int j = 1; j < 20; j++) cd_q[i][j] <= cd_q[i][j-1];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rdata[i] = {9{a2_q[i][7:0]}};
      cdone[i] = cv_q[i][19] | inj[i];
      cres[i]  = cd_q[i][19];
    end
  end

  // ---------------- Monitor: logs writes, done pulses, occupancy ----------------
  int              wlog_n [2];
  logic [AW-1:0]   wa  [2][256];
  logic [8:0][7:0] wdl [2][256];
  int              done_n [2];
  int              dlog [2][16];
  int              vcount [2];
  int              peak [2];
  int              simul [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        vcount[i] = wlog_n[i];
      end else begin
        if (cvalid[i]) vcount[i]++;
        if (we[i]) begin
          if (wlog_n[i] < 256) begin
            wa[i][wlog_n[i]]  = waddr[i];
            wdl[i][wlog_n[i]] = wdata[i];
          end
          wlog_n[i]++;
        end
        if (cvalid[i] && we[i]) simul[i]++;
        if (vcount[i] - wlog_n[i] > peak[i]) peak[i] = vcount[i] - wlog_n[i];
        if (sdone[i]) begin
          if (done_n[i] < 16) dlog[i][done_n[i]] = wlog_n[i];
          done_n[i]++;
        end
      end
    end
  end

  // ---------------- Checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_data(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input int i, input string tag);
    check({tag, " raddr"},  raddr[i], 0);
    check({tag, " cvalid"}, cvalid[i], 0);
    check_data({tag, " cdata"}, cdata[i], '0);
    check({tag, " we"},     we[i], 0);
    check({tag, " waddr"},  waddr[i], 0);
    check_data({tag, " wdata"}, wdata[i], '0);
    check({tag, " busy"},   busy[i], 0);
    check({tag, " done"},   sdone[i], 0);
    check({tag, " error"},  err[i], 0);
  endtask

  // One full sweep on instance inst. extra: pulse start again mid-sweep.
  // b2b: return on the cycle after sweep_done so the caller can restart at once.
  task automatic run_sweep(input int inst, input bit extra, input int exp_w,
                           input bit exp_err, input bit b2b);
    int  base, dbase, navail;
    bit  seen;
    logic [7:0] b;
    base  = wlog_n[inst];
    dbase = done_n[inst];
    start[inst] = 1'b1;
    @(negedge clk);
    start[inst] = 1'b0;
    check($sformatf("busy after start i%0d", inst), busy[inst], 1);
    if (extra) begin
      repeat (2) @(negedge clk);
      check($sformatf("busy at restart1 i%0d", inst), busy[inst], 1);
      start[inst] = 1'b1;
      @(negedge clk);
      start[inst] = 1'b0;
      repeat (8) @(negedge clk);
      check($sformatf("busy at restart2 i%0d", inst), busy[inst], 1);
      start[inst] = 1'b1;
      @(negedge clk);
      start[inst] = 1'b0;
    end
    seen = 1'b0;
    for (int t = 0; t < 3000 && !seen; t++) begin
      if (sdone[inst]) seen = 1'b1;
      else @(negedge clk);
    end
    check($sformatf("sweep_done seen i%0d", inst), seen, 1);
    @(negedge clk);
    if (!b2b) repeat (30) @(negedge clk);
    check($sformatf("write count i%0d", inst), wlog_n[inst] - base, exp_w);
    navail = wlog_n[inst] - base;
    if (navail > exp_w) navail = exp_w;
    for (int j = 0; j < navail; j++) begin
      b = 8'(j + 1);
      check($sformatf("waddr i%0d #%0d", inst, j), wa[inst][base + j], j);
      check_data($sformatf("wdata i%0d #%0d", inst, j), wdl[inst][base + j], {9{b}});
    end
    check($sformatf("done pulses i%0d", inst), done_n[inst] - dbase, 1);
    check($sformatf("done after last write i%0d", inst), dlog[inst][dbase], base + exp_w);
    check($sformatf("error i%0d", inst), err[inst], exp_err);
  endtask

  typedef struct {
    int inst;
    bit extra;
    int exp_writes;
    bit exp_err;
  } sweep_vec_t;

  sweep_vec_t tbl [4];

  initial begin : main
    int s0, w0;
    tbl[0] = '{inst: 0, extra: 1'b0, exp_writes: 4,  exp_err: 1'b0};
    tbl[1] = '{inst: 0, extra: 1'b1, exp_writes: 4,  exp_err: 1'b0};
    tbl[2] = '{inst: 1, extra: 1'b0, exp_writes: 16, exp_err: 1'b0};
    tbl[3] = '{inst: 1, extra: 1'b1, exp_writes: 16, exp_err: 1'b0};

    // Reset state.
    repeat (3) @(negedge clk);
    check_outputs_zero(0, "reset i0");
    check_outputs_zero(1, "reset i1");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven sweeps.
    for (int k = 0; k < 4; k++)
      run_sweep(tbl[k].inst, tbl[k].extra, tbl[k].exp_writes, tbl[k].exp_err, 1'b0);

    // In-flight cells never exceed FIFO_DEPTH=4, and the limit is reached.
    check("peak outstanding i1", peak[1], 4);

    // Back-to-back sweeps on the stalling instance.
    s0 = simul[1];
    run_sweep(1, 1'b0, 16, 1'b0, 1'b1);
    run_sweep(1, 1'b0, 16, 1'b0, 1'b0);
    check("simultaneous push/pop seen", (simul[1] - s0) > 0, 1);

    // Stray coll_done while idle: no write, sticky error.
    w0 = wlog_n[0];
    check("error before stray done", err[0], 0);
    inj[0] = 1'b1;
    #1;
    check("we on stray done", we[0], 0);
    @(negedge clk);
    inj[0] = 1'b0;
    check("error after stray done", err[0], 1);
    repeat (10) @(negedge clk);
    check("error held", err[0], 1);
    check("no write from stray done", wlog_n[0] - w0, 0);
    check("other instance error", err[1], 0);

    // Asynchronous reset five cycles into ISSUE.
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("busy before mid reset", busy[1], 1);
    rst = 1'b1;
    #1;
    check_outputs_zero(1, "mid reset i1");
    check("error cleared by reset i0", err[0], 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_sweep(1, 1'b0, 16, 1'b0, 1'b0);
    run_sweep(0, 1'b0, 4, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
